regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back scheduler for the 32x32 register file, which has a single write port (RD/WData/RegWr). Two producers share that port: the single-cycle ALU path (port 0) and the multi-cycle load/mul path (port 1). Each producer has a small FIFO, and the block grants one write per cycle round-robin. It also keeps a pending-write scoreboard so the decode stage can stall on RAW hazards.

Parameters:
DW, 32, data width
AW, 5, register address width (2**AW registers)
DEPTH, 2, entries per requester FIFO (power of 2, >=2)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
W0Valid  in  1  ALU write-back request
W0Rd  in  AW  ALU destination register
W0Data  in  DW  ALU result
W0Ready  out  1  port-0 FIFO not full
W1Valid  in  1  load/mul write-back request
W1Rd  in  AW  load/mul destination register
W1Data  in  DW  load/mul result
W1Ready  out  1  port-1 FIFO not full
IssueValid  in  1  decode issues an instruction that will write IssueRd
IssueRd  in  AW  destination of the issued instruction
RS1, RS2  in  AW each  decode source-operand queries
Busy1, Busy2  out  1 each  pending write to RS1/RS2 (combinational)
RD  out  AW  register-file write address
WData  out  DW  register-file write data
RegWr  out  1  register-file write enable

Behaviour:
- Reset is asynchronous and active-high, and has the same effect whenever it is asserted, including mid-operation:
  - both FIFOs are emptied and all queued data is discarded;
  - the round-robin pointer is set to 0 (port 0 favoured);
  - the scoreboard is cleared.
- Reset values of outputs: RegWr=0, RD=0, WData=0, W0Ready=W1Ready=1, Busy1=Busy2=0.
- Handshake: an entry is pushed on the rising edge when WxValid && WxReady. WxReady = !fullx and does not depend on WxValid. Valid while not ready: no push; the requester holds its values.
- Arbitration, each cycle over FIFO heads:
  - only one FIFO non-empty: it is granted;
  - both non-empty: grant goes to the port indicated by the pointer, and the pointer then flips to the other port;
  - neither non-empty: no grant, RegWr=0.
  - The pointer changes only when both FIFOs contend.
- Granted head drives RD/WData combinationally and pops on the same edge. RegWr = grant && head.rd != 0.
  - Rd=0 entries still pop and still count as the grant, but produce no write.
- When RegWr=0, RD and WData are driven 0.
- Latency (macro off): a push at edge N gives RegWr high in cycle N+1 at the earliest. A blocked port waits at most 1 cycle per queued entry of the other port.
- FIFO boundaries:
  - push and pop on a full FIFO in the same cycle is not possible, because ready is already 0;
  - push and pop on a non-empty FIFO in the same cycle leaves the count unchanged;
  - pointers wrap modulo DEPTH.
- Scoreboard (2**AW pending bits, bit 0 hardwired 0):
  - IssueValid sets pending[IssueRd];
  - a completed RegWr clears pending[RD];
  - set and clear of the same register in the same cycle: set wins, because the new issue supersedes.
- BusyN = pending[RSN], with RSN=0 always giving 0. A register being written this cycle still reads Busy=1 until the next edge.
- No ordering guarantee across ports for the same Rd. Decode must not issue a second writer to a busy register; the block does not check this.

Optional Feature:
WB_BYPASS_EN
- Defined: when the granted port's FIFO is empty and WxValid is high, the request goes straight to RD/WData/RegWr in the same cycle, with no push.
  - This gives 0-cycle latency.
  - The bypass request takes part in arbitration exactly like a head entry.
  - A bypassed request that loses arbitration is pushed normally.
  - BusyN also reads 0 for RSN==RD while RegWr=1.
- Undefined: all requests go through the FIFOs, with 1-cycle minimum latency.

Test Plan:
- Reset then idle: RegWr=0, RD=0, WData=0, W0Ready=W1Ready=1, Busy1=Busy2=0.
- Single write: W0Valid=1, W0Rd=5, W0Data=0xDEADBEEF for 1 cycle -> next cycle RegWr=1, RD=5, WData=0xDEADBEEF. With WB_BYPASS_EN the write appears in the same cycle.
- Contention: push port0 (Rd3, 0x11) and port1 (Rd4, 0x22) together after reset -> writes Rd3 then Rd4 on consecutive cycles. Repeat the pair -> Rd4 data written first, because the pointer flipped.
- Full: hold W1Valid with port 0 saturating arbitration -> W1Ready=0 after DEPTH=2 accepted entries, no loss, entries drain in order.
- Scoreboard: IssueValid with IssueRd=7; RS1=7 -> Busy1=1. Writeback to Rd7 -> Busy1=0 the next cycle. Issue and writeback of Rd7 in the same cycle -> Busy1 stays 1. RS2=0 -> Busy2=0 always.
- Rd0 write dropped and reset mid-queue: push Rd0, 0xFFFF -> RegWr stays 0 and the FIFO empties. Queue 2 entries, assert Reset -> RegWr=0 immediately, queue and scoreboard empty, no stale write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back scheduler for the single-write-port register file.
// Two producers share the write port: port 0 is the ALU path and port 1 is the
// load/mul path. Each producer has a small FIFO. Heads are granted round-robin,
// and a pending-write scoreboard lets decode stall on RAW hazards.
// Optional build macro: WB_BYPASS_EN. When it is defined, a request whose FIFO is
// empty may be written in the same cycle without being queued.
module regfile_wb_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          W0Valid,
    input  logic [AW-1:0] W0Rd,
    input  logic [DW-1:0] W0Data,
    output logic          W0Ready,
    input  logic          W1Valid,
    input  logic [AW-1:0] W1Rd,
    input  logic [DW-1:0] W1Data,
    output logic          W1Ready,
    input  logic          IssueValid,
    input  logic [AW-1:0] IssueRd,
    input  logic [AW-1:0] RS1,
    input  logic [AW-1:0] RS2,
    output logic          Busy1,
    output logic          Busy2,
    output logic [AW-1:0] RD,
    output logic [DW-1:0] WData,
    output logic          RegWr
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 2 ** AW;

    // Port 0 FIFO storage and bookkeeping
    logic [AW-1:0] r_rd0   [DEPTH];
    logic [DW-1:0] r_data0 [DEPTH];
    logic [PW-1:0] r_wp0;
    logic [PW-1:0] r_rp0;
    logic [CW-1:0] r_cnt0;

    // Port 1 FIFO storage and bookkeeping
    logic [AW-1:0] r_rd1   [DEPTH];
    logic [DW-1:0] r_data1 [DEPTH];
    logic [PW-1:0] r_wp1;
    logic [PW-1:0] r_rp1;
    logic [CW-1:0] r_cnt1;

    // Round-robin pointer: 0 favours port 0 on the next contention
    logic r_ptr;

    // One pending bit per architectural register
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pendingNext;

    logic          w_empty0;
    logic          w_empty1;
    logic          w_full0;
    logic          w_full1;
    logic          w_byp0;
    logic          w_byp1;
    logic          w_req0;
    logic          w_req1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_contend;
    logic          w_pop0;
    logic          w_pop1;
    logic          w_push0;
    logic          w_push1;
    logic [AW-1:0] w_headRd0;
    logic [DW-1:0] w_headData0;
    logic [AW-1:0] w_headRd1;
    logic [DW-1:0] w_headData1;
    logic [AW-1:0] w_selRd;
    logic [DW-1:0] w_selData;
    logic          w_wr;
    logic          w_busy1;
    logic          w_busy2;

    assign w_empty0 = (r_cnt0 == '0);
    assign w_empty1 = (r_cnt1 == '0);
    assign w_full0  = (r_cnt0 == CW'(DEPTH));
    assign w_full1  = (r_cnt1 == CW'(DEPTH));

`ifdef WB_BYPASS_EN
    // An empty FIFO lets the live request compete as if it were the head
    assign w_byp0 = w_empty0 && W0Valid;
    assign w_byp1 = w_empty1 && W1Valid;
`else
    assign w_byp0 = 1'b0;
    assign w_byp1 = 1'b0;
`endif

    assign w_req0 = !w_empty0 || w_byp0;
    assign w_req1 = !w_empty1 || w_byp1;

    // The head is the live input only when the FIFO is empty (bypass case)
    assign w_headRd0   = w_empty0 ? W0Rd   : r_rd0[r_rp0];
    assign w_headData0 = w_empty0 ? W0Data : r_data0[r_rp0];
    assign w_headRd1   = w_empty1 ? W1Rd   : r_rd1[r_rp1];
    assign w_headData1 = w_empty1 ? W1Data : r_data1[r_rp1];

    assign w_contend = w_req0 && w_req1;
    assign w_gnt0    = w_req0 && (!w_req1 || (r_ptr == 1'b0));
    assign w_gnt1    = w_req1 && (!w_req0 || (r_ptr == 1'b1));

    // A granted bypass request is consumed directly and is never queued
    assign w_pop0  = w_gnt0 && !w_empty0;
    assign w_pop1  = w_gnt1 && !w_empty1;
    assign w_push0 = W0Valid && !w_full0 && !(w_gnt0 && w_byp0);
    assign w_push1 = W1Valid && !w_full1 && !(w_gnt1 && w_byp1);

    // Select the granted head; Rd 0 entries are consumed without writing
    always_comb begin
        w_selRd   = '0;
        w_selData = '0;
        if (w_gnt0) begin
            w_selRd   = w_headRd0;
            w_selData = w_headData0;
        end else if (w_gnt1) begin
            w_selRd   = w_headRd1;
            w_selData = w_headData1;
        end
    end

    assign w_wr    = (w_gnt0 || w_gnt1) && (w_selRd != '0);
    assign RegWr   = w_wr;
    assign RD      = w_wr ? w_selRd : '0;
    assign WData   = w_wr ? w_selData : '0;
    assign W0Ready = !w_full0;
    assign W1Ready = !w_full1;

    // Busy is a plain scoreboard lookup; register 0 is never pending
    always_comb begin
        w_busy1 = (RS1 != '0) && r_pending[RS1];
        w_busy2 = (RS2 != '0) && r_pending[RS2];
`ifdef WB_BYPASS_EN
        if (w_wr && (RD == RS1)) begin
            w_busy1 = 1'b0;
        end
        if (w_wr && (RD == RS2)) begin
            w_busy2 = 1'b0;
        end
`endif
    end

    assign Busy1 = w_busy1;
    assign Busy2 = w_busy2;

    // Port 0 FIFO data array; contents need no reset because the count gates use
    always_ff @(posedge Clk) begin
        if (w_push0) begin
            r_rd0[r_wp0]   <= W0Rd;
            r_data0[r_wp0] <= W0Data;
        end
    end

    // Port 0 FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wp0  <= '0;
            r_rp0  <= '0;
            r_cnt0 <= '0;
        end else begin
            if (w_push0) begin
                r_wp0 <= r_wp0 + PW'(1);
            end
            if (w_pop0) begin
                r_rp0 <= r_rp0 + PW'(1);
            end
            if (w_push0 && !w_pop0) begin
                r_cnt0 <= r_cnt0 + CW'(1);
            end else if (!w_push0 && w_pop0) begin
                r_cnt0 <= r_cnt0 - CW'(1);
            end
        end
    end

    // Port 1 FIFO data array
    always_ff @(posedge Clk) begin
        if (w_push1) begin
            r_rd1[r_wp1]   <= W1Rd;
            r_data1[r_wp1] <= W1Data;
        end
    end

    // Port 1 FIFO pointers and occupancy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wp1  <= '0;
            r_rp1  <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push1) begin
                r_wp1 <= r_wp1 + PW'(1);
            end
            if (w_pop1) begin
                r_rp1 <= r_rp1 + PW'(1);
            end
            if (w_push1 && !w_pop1) begin
                r_cnt1 <= r_cnt1 + CW'(1);
            end else if (!w_push1 && w_pop1) begin
                r_cnt1 <= r_cnt1 - CW'(1);
            end
        end
    end

    // Round-robin pointer moves only when both ports contend
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= 1'b0;
        end else if (w_contend) begin
            r_ptr <= ~r_ptr;
        end
    end

    // Scoreboard next state: clear on completed write, then a new issue wins
    always_comb begin
        w_pendingNext = r_pending;
        if (w_wr) begin
            w_pendingNext[RD] = 1'b0;
        end
        if (IssueValid) begin
            w_pendingNext[IssueRd] = 1'b1;
        end
        w_pendingNext[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Each cycle the driver applies inputs and a
// queue-based reference model predicts that cycle's outputs into a scoreboard
// queue. An independent monitor pops each prediction and compares it to the DUT.
// The model follows WB_BYPASS_EN in the same way the design does.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int NREG  = 2 ** AW;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          W0Valid;
    logic [AW-1:0] W0Rd;
    logic [DW-1:0] W0Data;
    logic          W0Ready;
    logic          W1Valid;
    logic [AW-1:0] W1Rd;
    logic [DW-1:0] W1Data;
    logic          W1Ready;
    logic          IssueValid;
    logic [AW-1:0] IssueRd;
    logic [AW-1:0] RS1;
    logic [AW-1:0] RS2;
    logic          Busy1;
    logic          Busy2;
    logic [AW-1:0] RD;
    logic [DW-1:0] WData;
    logic          RegWr;

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset),
        .W0Valid(W0Valid), .W0Rd(W0Rd), .W0Data(W0Data), .W0Ready(W0Ready),
        .W1Valid(W1Valid), .W1Rd(W1Rd), .W1Data(W1Data), .W1Ready(W1Ready),
        .IssueValid(IssueValid), .IssueRd(IssueRd),
        .RS1(RS1), .RS2(RS2), .Busy1(Busy1), .Busy2(Busy2),
        .RD(RD), .WData(WData), .RegWr(RegWr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          regWr;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          rdy0;
        logic          rdy1;
        logic          busy1;
        logic          busy2;
    } expT;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entT;

    expT  expQ[$];
    entT  q0[$];
    entT  q1[$];
    bit   rrPtr;
    bit   pend [NREG];
    bit   mAcc0;
    bit   mAcc1;
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    // Reference model: the per-port queues and a favoured-port bit give the order of writes
    task automatic modelCycle();
        expT e;
        entT h0, h1, w, tmp;
        bit  byp0, byp1, req0, req1, g0, g1, push0, push1;
        int  n0, n1;
        n0 = q0.size();
        n1 = q1.size();
        e.regWr = 1'b0; e.rd = '0; e.data = '0;
        e.rdy0 = 1'b1; e.rdy1 = 1'b1; e.busy1 = 1'b0; e.busy2 = 1'b0;
        if (Reset) begin
            q0.delete();
            q1.delete();
            rrPtr = 1'b0;
            foreach (pend[i]) pend[i] = 1'b0;
            mAcc0 = 1'b0;
            mAcc1 = 1'b0;
            expQ.push_back(e);
            return;
        end
        byp0 = 1'b0;
        byp1 = 1'b0;
`ifdef WB_BYPASS_EN
        byp0 = (n0 == 0) && W0Valid;
        byp1 = (n1 == 0) && W1Valid;
`endif
        req0 = (n0 > 0) || byp0;
        req1 = (n1 > 0) || byp1;
        if (n0 > 0) h0 = q0[0];
        else begin h0.rd = W0Rd; h0.data = W0Data; end
        if (n1 > 0) h1 = q1[0];
        else begin h1.rd = W1Rd; h1.data = W1Data; end
        g0 = req0 && (!req1 || !rrPtr);
        g1 = req1 && (!req0 || rrPtr);
        if (req0 && req1) rrPtr = !rrPtr;
        w.rd = '0; w.data = '0;
        if (g0) w = h0;
        else if (g1) w = h1;
        if ((g0 || g1) && (w.rd != 0)) begin
            e.regWr = 1'b1;
            e.rd    = w.rd;
            e.data  = w.data;
        end
        e.rdy0  = (n0 < DEPTH);
        e.rdy1  = (n1 < DEPTH);
        e.busy1 = (RS1 != 0) && pend[RS1];
        e.busy2 = (RS2 != 0) && pend[RS2];
`ifdef WB_BYPASS_EN
        if (e.regWr && (e.rd == RS1)) e.busy1 = 1'b0;
        if (e.regWr && (e.rd == RS2)) e.busy2 = 1'b0;
`endif
        expQ.push_back(e);
        if (g0 && (n0 > 0)) tmp = q0.pop_front();
        if (g1 && (n1 > 0)) tmp = q1.pop_front();
        push0 = W0Valid && e.rdy0 && !(g0 && byp0);
        push1 = W1Valid && e.rdy1 && !(g1 && byp1);
        if (push0) begin tmp.rd = W0Rd; tmp.data = W0Data; q0.push_back(tmp); end
        if (push1) begin tmp.rd = W1Rd; tmp.data = W1Data; q1.push_back(tmp); end
        mAcc0 = push0 || (g0 && byp0);
        mAcc1 = push1 || (g1 && byp1);
        if (e.regWr) pend[e.rd] = 1'b0;
        if (IssueValid) pend[IssueRd] = 1'b1;
        pend[0] = 1'b0;
    endtask

    // Drive one cycle of inputs on the falling edge, then record the model's prediction
    task automatic applyStimulus(input bit rst,
                                 input bit v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                                 input bit v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1,
                                 input bit iv, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        @(negedge Clk);
        Reset = rst;
        W0Valid = v0; W0Rd = rd0; W0Data = d0;
        W1Valid = v1; W1Rd = rd1; W1Data = d1;
        IssueValid = iv; IssueRd = ird;
        RS1 = rs1; RS2 = rs2;
        #1;
        modelCycle();
    endtask

    task automatic idle(input int n, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rs1, rs2);
    endtask

    // Randomised traffic; a request not accepted is held unchanged until it is
    task automatic runTraffic(input int n, input int p0, input int p1, input int pIssue);
        bit            c0v, c1v, iv;
        logic [AW-1:0] c0rd, c1rd, ird, rs1, rs2;
        logic [DW-1:0] c0d, c1d;
        c0v = 0; c1v = 0; c0rd = '0; c1rd = '0; c0d = '0; c1d = '0;
        for (int i = 0; i < n; i++) begin
            if (!(c0v && !mAcc0)) begin
                c0v  = ($urandom_range(0, 99) < p0);
                c0rd = AW'($urandom_range(0, NREG - 1));
                c0d  = $urandom;
            end
            if (!(c1v && !mAcc1)) begin
                c1v  = ($urandom_range(0, 99) < p1);
                c1rd = AW'($urandom_range(0, NREG - 1));
                c1d  = $urandom;
            end
            iv  = ($urandom_range(0, 99) < pIssue);
            ird = AW'($urandom_range(0, NREG - 1));
            rs1 = AW'($urandom_range(0, NREG - 1));
            rs2 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, NREG - 1));
            applyStimulus(0, c0v, c0rd, c0d, c1v, c1rd, c1d, iv, ird, rs1, rs2);
        end
    endtask

    task automatic checkOutput(input expT e);
        checks++;
        if (RegWr !== e.regWr || RD !== e.rd || WData !== e.data ||
            W0Ready !== e.rdy0 || W1Ready !== e.rdy1 || Busy1 !== e.busy1 || Busy2 !== e.busy2) begin
            errors++;
            $display("[TB] FAIL cycle%0d outputs: got RegWr=%b RD=%0d WData=%h Rdy=%b%b Busy=%b%b, want RegWr=%b RD=%0d WData=%h Rdy=%b%b Busy=%b%b",
                     cycleNo, RegWr, RD, WData, W0Ready, W1Ready, Busy1, Busy2,
                     e.regWr, e.rd, e.data, e.rdy0, e.rdy1, e.busy1, e.busy2);
        end
    endtask

    // Monitor: pops one prediction per cycle, sampled 2 time units after the falling edge
    initial begin
        expT e;
        forever begin
            @(negedge Clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
                cycleNo++;
            end
        end
    end

    initial begin
        Reset = 1'b1;
        W0Valid = 0; W0Rd = '0; W0Data = '0;
        W1Valid = 0; W1Rd = '0; W1Data = '0;
        IssueValid = 0; IssueRd = '0; RS1 = '0; RS2 = '0;
        rrPtr = 1'b0; mAcc0 = 1'b0; mAcc1 = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;

        // Reset, then idle
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 5, 0);

        // Single write
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Contention twice; the second pair is written in the reverse order
        applyStimulus(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        idle(3, 0, 0);
        applyStimulus(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        idle(3, 0, 0);

        // Both ports saturated so that port 1 fills and back-pressures
        runTraffic(10, 100, 100, 0);
        idle(5, 0, 0);

        // Scoreboard: issue, write back, then issue and write back together
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(1, 7, 0);
        applyStimulus(0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        idle(2, 7, 0);
        applyStimulus(0, 1, 7, 32'h78, 0, 0, 0, 1, 7, 7, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7);
        idle(2, 7, 0);

        // Rd 0 entry is consumed without a write
        applyStimulus(0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);

        // Reset while entries are queued and registers are pending
        applyStimulus(0, 1, 9, 32'hA1, 1, 10, 32'hB1, 1, 9, 9, 10);
        applyStimulus(0, 1, 11, 32'hA2, 1, 12, 32'hB2, 1, 10, 9, 10);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 10);
        idle(3, 9, 10);

        // Random traffic
        runTraffic(400, 60, 60, 30);
        idle(6, 0, 0);

        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d unchecked predictions, want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
